// File: rtl/irq_ctrl_pkg.sv
// Shared register map for the interrupt controller, used by the bridge decoder and benches.
package irq_ctrl_pkg;

  localparam logic [2:0] IRQ_PEND   = 3'd0;
  localparam logic [2:0] IRQ_MASK   = 3'd1;
  localparam logic [2:0] IRQ_MODE   = 3'd2;
  localparam logic [2:0] IRQ_ACTIVE = 3'd3;
  localparam logic [2:0] IRQ_SWTRIG = 3'd4;

  localparam int ACTIVE_VALID_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the masked pending vector.
module irq_prio_enc #(
  parameter int NSRC = 6
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: level/edge latching of device lines, Pr-bus register file, registered HWInt.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] IrqSrc,
  input  logic            Sel,
  input  logic [2:0]      Addr,
  input  logic            We,
  input  logic [31:0]     WData,
  output logic [31:0]     RData,
  output logic [NSRC-1:0] HWInt
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] swtrig;
  logic            wr;
  logic            act_valid;
  logic [2:0]      act_idx;
  logic            unused_wdata;

  assign wr           = Sel & We;
  assign rise         = src_q & ~src_d;
  assign w1c          = (wr && Addr == IRQ_PEND)   ? WData[NSRC-1:0] : '0;
  assign swtrig       = (wr && Addr == IRQ_SWTRIG) ? WData[NSRC-1:0] : '0;
  assign unused_wdata = ^WData;

  // Level bits track the synchronised line; edge bits hold until cleared, and a set beats a clear.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (mode[i]) pend_next[i] = (pend[i] & ~w1c[i]) | rise[i] | swtrig[i];
      else         pend_next[i] = src_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      src_d <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      HWInt <= '0;
    end else begin
      src_q <= IrqSrc;
      src_d <= src_q;
      pend  <= pend_next;
      if (wr && Addr == IRQ_MASK) mask <= WData[NSRC-1:0];
      if (wr && Addr == IRQ_MODE) mode <= WData[NSRC-1:0];
      HWInt <= pend & mask;
    end
  end

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (pend & mask),
    .valid (act_valid),
    .idx   (act_idx)
  );

  always_comb begin
    RData = '0;
    case (Addr)
      IRQ_PEND:   RData = 32'(pend);
      IRQ_MASK:   RData = 32'(mask);
      IRQ_MODE:   RData = 32'(mode);
      IRQ_ACTIVE: begin
        RData                   = 32'(act_idx);
        RData[ACTIVE_VALID_BIT] = act_valid;
      end
      default:    RData = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed register reads and HWInt values at fixed edges.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  IrqSrc = '0;
  logic        Sel = 1'b0;
  logic [2:0]  Addr = '0;
  logic        We = 1'b0;
  logic [31:0] WData = '0;
  logic [31:0] RData;
  logic [5:0]  HWInt;

  int n_assert = 0;
  int n_fail   = 0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .IrqSrc (IrqSrc),
    .Sel    (Sel),
    .Addr   (Addr),
    .We     (We),
    .WData  (WData),
    .RData  (RData),
    .HWInt  (HWInt)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    check(tag, RData, exp);
  endtask

  task automatic chk_hw(input string tag, input logic [5:0] exp);
    check(tag, {26'b0, HWInt}, {26'b0, exp});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic sel);
    Sel = sel; We = 1'b1; Addr = a; WData = d;
    tick();
    Sel = 1'b0; We = 1'b0; WData = '0;
  endtask

  initial begin
    // 1: reset state
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) chk_rd($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
    chk_hw("rst_hwint", 6'h00);

    // 2: level mode, three-edge latency in and out
    tick();
    wr_reg(IRQ_MASK, 32'h3F, 1'b1);
    wr_reg(IRQ_MODE, 32'h00, 1'b1);
    IrqSrc = 6'h04;
    tick(); tick();
    chk_rd("lvl_pend_e2", IRQ_PEND, 32'h04);
    chk_hw("lvl_hw_e2", 6'h00);
    tick();
    chk_hw("lvl_hw_e3", 6'h04);
    chk_rd("lvl_active", IRQ_ACTIVE, 32'h8000_0002);
    IrqSrc = 6'h00;
    tick(); tick();
    chk_hw("lvl_drop_e2", 6'h04);
    tick();
    chk_hw("lvl_drop_e3", 6'h00);
    chk_rd("lvl_active_off", IRQ_ACTIVE, 32'h0);

    // 3: edge mode latches a one-cycle pulse, W1C clears it
    wr_reg(IRQ_MODE, 32'h01, 1'b1);
    wr_reg(IRQ_MASK, 32'h01, 1'b1);
    IrqSrc = 6'h01;
    tick();
    IrqSrc = 6'h00;
    tick(); tick(); tick();
    chk_rd("edge_pend_hold", IRQ_PEND, 32'h01);
    chk_hw("edge_hw", 6'h01);
    wr_reg(IRQ_PEND, 32'h01, 1'b1);
    chk_rd("w1c_pend", IRQ_PEND, 32'h00);
    chk_hw("w1c_hw_commit", 6'h01);
    tick();
    chk_hw("w1c_hw_next", 6'h00);

    // 4: set wins over a same-cycle clear
    IrqSrc = 6'h01;
    tick();
    IrqSrc = 6'h00;
    wr_reg(IRQ_PEND, 32'h01, 1'b1);
    chk_rd("set_wins", IRQ_PEND, 32'h01);
    tick(); tick();
    chk_rd("no_second_rise", IRQ_PEND, 32'h01);
    wr_reg(IRQ_PEND, 32'h01, 1'b1);
    chk_rd("w1c_after_race", IRQ_PEND, 32'h00);

    // 5: software trigger only on edge-mode bits, mask gating and ACTIVE index
    wr_reg(IRQ_MODE, 32'h30, 1'b1);
    wr_reg(IRQ_MASK, 32'h00, 1'b1);
    wr_reg(IRQ_SWTRIG, 32'h3F, 1'b1);
    chk_rd("swtrig_pend", IRQ_PEND, 32'h30);
    chk_rd("swtrig_rd0", IRQ_SWTRIG, 32'h0);
    tick();
    chk_hw("swtrig_masked", 6'h00);
    wr_reg(IRQ_MASK, 32'h20, 1'b1);
    chk_hw("mask_commit_edge", 6'h00);
    chk_rd("active_5", IRQ_ACTIVE, 32'h8000_0005);
    tick();
    chk_hw("mask_next_edge", 6'h20);
    wr_reg(IRQ_MASK, 32'h3F, 1'b0);
    chk_rd("nosel_ignored", IRQ_MASK, 32'h20);
    wr_reg(3'd5, 32'hFFFF_FFFF, 1'b1);
    chk_rd("off5_rd0", 3'd5, 32'h0);
    chk_rd("mode_kept", IRQ_MODE, 32'h30);

    // 6: mid-cycle asynchronous reset, then release with a level source high
    wr_reg(IRQ_MODE, 32'h09, 1'b1);
    wr_reg(IRQ_SWTRIG, 32'h09, 1'b1);
    wr_reg(IRQ_MASK, 32'h09, 1'b1);
    chk_rd("pre_rst_pend", IRQ_PEND, 32'h09);
    tick();
    chk_hw("pre_rst_hw", 6'h09);
    #3;
    reset = 1'b0;
    IrqSrc = 6'h08;
    #1;
    chk_hw("async_rst_hw", 6'h00);
    chk_rd("async_rst_pend", IRQ_PEND, 32'h0);
    chk_rd("async_rst_mask", IRQ_MASK, 32'h0);
    chk_rd("async_rst_mode", IRQ_MODE, 32'h0);
    chk_rd("async_rst_active", IRQ_ACTIVE, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk_rd("post_rst_e1", IRQ_PEND, 32'h00);
    tick();
    chk_rd("post_rst_pend", IRQ_PEND, 32'h08);
    tick();
    chk_hw("post_rst_hw", 6'h00);
    chk_rd("post_rst_active", IRQ_ACTIVE, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
